// File: rtl/csr_spec_wbuf.sv
// Speculative CSR write buffer: holds uncommitted CSR writes in program order,
// retires them on ROB commit and forwards pending values to reads (CSR_FWD_EN).
module csr_spec_wbuf #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int ROB_W  = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enq_valid,
    output logic                   enq_ready,
    input  logic [ADDR_W-1:0]      enq_addr,
    input  logic [DATA_W-1:0]      enq_data,
    input  logic [DATA_W-1:0]      enq_mask,
    input  logic [ROB_W-1:0]       enq_rob_idx,
    input  logic                   commit_valid,
    input  logic [ROB_W-1:0]       commit_rob_idx,
    input  logic                   flush_valid,
    output logic                   csr_w_valid,
    output logic [ADDR_W-1:0]      csr_w_addr,
    output logic [DATA_W-1:0]      csr_w_data,
    output logic [DATA_W-1:0]      csr_w_mask,
    input  logic [ADDR_W-1:0]      rd_addr,
    input  logic [DATA_W-1:0]      rd_arch_data,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   rd_hit,
    output logic [$clog2(DEPTH):0] count,
    output logic                   commit_err
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] addr_r [DEPTH];
    logic [DATA_W-1:0] data_r [DEPTH];
    logic [DATA_W-1:0] mask_r [DEPTH];
    logic [ROB_W-1:0]  tag_r  [DEPTH];
    logic [DEPTH-1:0]  valid_r;
    logic [PTR_W:0]    head_r;
    logic [PTR_W:0]    tail_r;

    logic              csr_w_valid_r;
    logic [ADDR_W-1:0] csr_w_addr_r;
    logic [DATA_W-1:0] csr_w_data_r;
    logic [DATA_W-1:0] csr_w_mask_r;
    logic              commit_err_r;

    logic [PTR_W-1:0]  head_idx_s;
    logic [PTR_W-1:0]  tail_idx_s;
    logic              full_s;
    logic              empty_s;
    logic              commit_ok_s;
    logic              enq_ok_s;
    logic [DEPTH-1:0]  valid_nxt_s;
    logic [PTR_W-1:0]  hit_idx_s;
    logic              rd_hit_s;

    function automatic logic [DATA_W-1:0] mask_merge(input logic [DATA_W-1:0] old_v,
                                                     input logic [DATA_W-1:0] new_v,
                                                     input logic [DATA_W-1:0] msk);
        mask_merge = (old_v & ~msk) | (new_v & msk);
    endfunction

    assign head_idx_s  = head_r[PTR_W-1:0];
    assign tail_idx_s  = tail_r[PTR_W-1:0];
    assign full_s      = (head_idx_s == tail_idx_s) && (head_r[PTR_W] != tail_r[PTR_W]);
    assign empty_s     = (head_r == tail_r);
    // A freed head slot is not reusable in the same cycle, so readiness only looks at full.
    assign commit_ok_s = commit_valid && !empty_s && (commit_rob_idx == tag_r[head_idx_s]);
    assign enq_ok_s    = enq_valid && !full_s && !flush_valid;

    assign enq_ready   = !full_s;
    assign count       = tail_r - head_r;
    assign csr_w_valid = csr_w_valid_r;
    assign csr_w_addr  = csr_w_addr_r;
    assign csr_w_data  = csr_w_data_r;
    assign csr_w_mask  = csr_w_mask_r;
    assign commit_err  = commit_err_r;
    assign rd_hit      = rd_hit_s;

    // Next valid vector for a cycle without flush.
    always_comb begin
        valid_nxt_s = valid_r;
        if (commit_ok_s) begin
            valid_nxt_s[head_idx_s] = 1'b0;
        end else begin
            valid_nxt_s = valid_nxt_s;
        end
        if (enq_ok_s) begin
            valid_nxt_s[tail_idx_s] = 1'b1;
        end else begin
            valid_nxt_s = valid_nxt_s;
        end
    end

    // Pending-match detection, walking from head (oldest) towards tail.
    always_comb begin
        rd_hit_s  = 1'b0;
        hit_idx_s = {PTR_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            hit_idx_s = head_idx_s + PTR_W'(i);
            if (valid_r[hit_idx_s] && (addr_r[hit_idx_s] == rd_addr)) begin
                rd_hit_s = 1'b1;
            end else begin
                rd_hit_s = rd_hit_s;
            end
        end
    end

`ifdef CSR_FWD_EN
    logic [DATA_W-1:0] fwd_data_s;
    logic [PTR_W-1:0]  fwd_idx_s;

    // Age-ordered masked merge of every matching pending write over the architectural value.
    always_comb begin
        fwd_data_s = rd_arch_data;
        fwd_idx_s  = {PTR_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx_s = head_idx_s + PTR_W'(i);
            if (valid_r[fwd_idx_s] && (addr_r[fwd_idx_s] == rd_addr)) begin
                fwd_data_s = mask_merge(fwd_data_s, data_r[fwd_idx_s], mask_r[fwd_idx_s]);
            end else begin
                fwd_data_s = fwd_data_s;
            end
        end
    end

    assign rd_data = fwd_data_s;
`else
    // Without forwarding the consumer stalls on rd_hit, so the architectural value passes through.
    assign rd_data = rd_arch_data;
`endif

    // FIFO storage and pointers; flush keeps the tail and collapses the head onto it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_r[i] <= {ADDR_W{1'b0}};
                data_r[i] <= {DATA_W{1'b0}};
                mask_r[i] <= {DATA_W{1'b0}};
                tag_r[i]  <= {ROB_W{1'b0}};
            end
            valid_r <= {DEPTH{1'b0}};
            head_r  <= {(PTR_W+1){1'b0}};
            tail_r  <= {(PTR_W+1){1'b0}};
        end else begin
            if (enq_ok_s) begin
                addr_r[tail_idx_s] <= enq_addr;
                data_r[tail_idx_s] <= enq_data;
                mask_r[tail_idx_s] <= enq_mask;
                tag_r[tail_idx_s]  <= enq_rob_idx;
            end
            if (flush_valid) begin
                valid_r <= {DEPTH{1'b0}};
                head_r  <= tail_r;
            end else begin
                valid_r <= valid_nxt_s;
                head_r  <= head_r + {{PTR_W{1'b0}}, commit_ok_s};
                tail_r  <= tail_r + {{PTR_W{1'b0}}, enq_ok_s};
            end
        end
    end

    // Architectural write port and commit error pulse, refreshed every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csr_w_valid_r <= 1'b0;
            csr_w_addr_r  <= {ADDR_W{1'b0}};
            csr_w_data_r  <= {DATA_W{1'b0}};
            csr_w_mask_r  <= {DATA_W{1'b0}};
            commit_err_r  <= 1'b0;
        end else begin
            csr_w_valid_r <= commit_ok_s;
            commit_err_r  <= commit_valid && !commit_ok_s;
            if (commit_ok_s) begin
                csr_w_addr_r <= addr_r[head_idx_s];
                csr_w_data_r <= data_r[head_idx_s];
                csr_w_mask_r <= mask_r[head_idx_s];
            end
        end
    end

endmodule

// File: tb/tb_csr_spec_wbuf.sv
// Self-checking bench for csr_spec_wbuf: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_csr_spec_wbuf;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int ROB_W  = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enq_valid = 1'b0;
    logic              enq_ready;
    logic [ADDR_W-1:0] enq_addr = '0;
    logic [DATA_W-1:0] enq_data = '0;
    logic [DATA_W-1:0] enq_mask = '0;
    logic [ROB_W-1:0]  enq_rob_idx = '0;
    logic              commit_valid = 1'b0;
    logic [ROB_W-1:0]  commit_rob_idx = '0;
    logic              flush_valid = 1'b0;
    logic              csr_w_valid;
    logic [ADDR_W-1:0] csr_w_addr;
    logic [DATA_W-1:0] csr_w_data;
    logic [DATA_W-1:0] csr_w_mask;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [DATA_W-1:0] rd_arch_data = '0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_hit;
    logic [2:0]        count;
    logic              commit_err;

    int n_cmp = 0;
    int n_bad = 0;

    csr_spec_wbuf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROB_W(ROB_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_addr(enq_addr),
        .enq_data(enq_data), .enq_mask(enq_mask), .enq_rob_idx(enq_rob_idx),
        .commit_valid(commit_valid), .commit_rob_idx(commit_rob_idx),
        .flush_valid(flush_valid),
        .csr_w_valid(csr_w_valid), .csr_w_addr(csr_w_addr),
        .csr_w_data(csr_w_data), .csr_w_mask(csr_w_mask),
        .rd_addr(rd_addr), .rd_arch_data(rd_arch_data),
        .rd_data(rd_data), .rd_hit(rd_hit),
        .count(count), .commit_err(commit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] mask;
        logic [ROB_W-1:0]  tag;
    } entry_t;

    entry_t            mq[$];
    logic              m_wv = 1'b0;
    logic [ADDR_W-1:0] m_waddr = '0;
    logic [DATA_W-1:0] m_wdata = '0;
    logic [DATA_W-1:0] m_wmask = '0;
    logic              m_err = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a,
                                                     input logic [DATA_W-1:0] arch);
        logic [DATA_W-1:0] v;
        v = arch;
`ifdef CSR_FWD_EN
        foreach (mq[i]) begin
            if (mq[i].addr == a) v = (v & ~mq[i].mask) | (mq[i].data & mq[i].mask);
        end
`endif
        return v;
    endfunction

    function automatic logic model_hit(input logic [ADDR_W-1:0] a);
        logic h;
        h = 1'b0;
        foreach (mq[i]) begin
            if (mq[i].addr == a) h = 1'b1;
        end
        return h;
    endfunction

    // Reference model: update from the inputs seen at each rising edge.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_wv = 1'b0; m_waddr = '0; m_wdata = '0; m_wmask = '0; m_err = 1'b0;
            end else begin
                logic was_full, ok;
                was_full = (mq.size() == DEPTH);
                ok = commit_valid && (mq.size() != 0) && (mq[0].tag == commit_rob_idx);
                m_wv  = ok;
                m_err = commit_valid && !ok;
                if (ok) begin
                    m_waddr = mq[0].addr; m_wdata = mq[0].data; m_wmask = mq[0].mask;
                    void'(mq.pop_front());
                end
                if (flush_valid) mq.delete();
                else if (enq_valid && !was_full)
                    mq.push_back('{addr: enq_addr, data: enq_data, mask: enq_mask, tag: enq_rob_idx});
            end
        end
    end

    // Compare process: every falling edge, inputs are stable then.
    initial begin
        forever begin
            @(negedge clk);
            check("enq_ready", enq_ready, mq.size() != DEPTH);
            check("count", count, mq.size());
            check("csr_w_valid", csr_w_valid, m_wv);
            if (m_wv) begin
                check("csr_w_addr", csr_w_addr, m_waddr);
                check("csr_w_data", csr_w_data, m_wdata);
                check("csr_w_mask", csr_w_mask, m_wmask);
            end
            check("commit_err", commit_err, m_err);
            check("rd_hit", rd_hit, model_hit(rd_addr));
            check("rd_data", rd_data, model_read(rd_addr, rd_arch_data));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_enq(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input logic [DATA_W-1:0] m, input logic [ROB_W-1:0] t);
        enq_valid = v; enq_addr = a; enq_data = d; enq_mask = m; enq_rob_idx = t;
    endtask

    task automatic set_cmt(input logic v, input logic [ROB_W-1:0] t);
        commit_valid = v; commit_rob_idx = t;
    endtask

    initial begin
        logic [DATA_W-1:0] exp_fwd;
        // Reset state
        repeat (2) cyc();
        check("rst_count", count, 3'd0);
        check("rst_enq_ready", enq_ready, 1'b1);
        check("rst_csr_w_valid", csr_w_valid, 1'b0);
        check("rst_csr_w_addr", csr_w_addr, 14'd0);
        check("rst_commit_err", commit_err, 1'b0);
        rst_n = 1'b1;
        cyc();

        // Single write and commit of ERA
        set_enq(1'b1, 14'h6, 32'h1C00_0100, 32'hFFFF_FFFF, 6'd3);
        cyc();
        set_enq(1'b0, 14'h0, 32'h0, 32'h0, 6'd0);
        check("t1_count1", count, 3'd1);
        set_cmt(1'b1, 6'd3);
        cyc();
        set_cmt(1'b0, 6'd0);
        check("t1_wvalid", csr_w_valid, 1'b1);
        check("t1_waddr", csr_w_addr, 14'h6);
        check("t1_wdata", csr_w_data, 32'h1C00_0100);
        check("t1_count0", count, 3'd0);
        cyc();
        check("t1_wvalid_drop", csr_w_valid, 1'b0);

        // Fill to full, overflow ignored, commit while full blocks enqueue
        for (int i = 0; i < 4; i++) begin
            set_enq(1'b1, 14'h10 + 14'(i), 32'h1111_0000 + 32'(i), 32'hFFFF_FFFF, 6'(i));
            cyc();
        end
        check("t2_full_ready", enq_ready, 1'b0);
        check("t2_full_count", count, 3'd4);
        set_enq(1'b1, 14'h20, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 6'd9);
        cyc();
        check("t2_ovf_count", count, 3'd4);
        set_cmt(1'b1, 6'd0);
        cyc();
        set_enq(1'b0, 14'h0, 32'h0, 32'h0, 6'd0);
        set_cmt(1'b0, 6'd0);
        check("t2_cmt_full_count", count, 3'd3);
        check("t2_cmt_full_wdata", csr_w_data, 32'h1111_0000);
        for (int i = 1; i < 4; i++) begin
            set_cmt(1'b1, 6'(i));
            cyc();
        end
        set_cmt(1'b0, 6'd0);
        check("t2_drain_count", count, 3'd0);
        check("t2_last_wdata", csr_w_data, 32'h1111_0003);

        // Forwarding onto CRMD
        set_enq(1'b1, 14'h0, 32'h3, 32'h3, 6'd10); cyc();
        set_enq(1'b1, 14'h0, 32'h4, 32'h4, 6'd11); cyc();
        set_enq(1'b1, 14'h1, 32'hFFFF, 32'hFFFF_FFFF, 6'd12); cyc();
        set_enq(1'b0, 14'h0, 32'h0, 32'h0, 6'd0);
        rd_addr = 14'h0; rd_arch_data = 32'h0000_0008;
        #1;
`ifdef CSR_FWD_EN
        exp_fwd = 32'h0000_000F;
`else
        exp_fwd = 32'h0000_0008;
`endif
        check("t3_rd_data", rd_data, exp_fwd);
        check("t3_rd_hit", rd_hit, 1'b1);
        rd_addr = 14'h5;
        set_enq(1'b1, 14'h5, 32'h1, 32'h1, 6'd13);
        #1;
        check("t3_same_cycle_hit", rd_hit, 1'b0);
        check("t3_same_cycle_data", rd_data, 32'h0000_0008);
        cyc();
        set_enq(1'b0, 14'h0, 32'h0, 32'h0, 6'd0);
`ifdef CSR_FWD_EN
        exp_fwd = 32'h0000_0009;
`else
        exp_fwd = 32'h0000_0008;
`endif
        check("t3_next_hit", rd_hit, 1'b1);
        check("t3_next_data", rd_data, exp_fwd);

        // Illegal commit: wrong tag
        set_cmt(1'b1, 6'd5);
        cyc();
        set_cmt(1'b0, 6'd0);
        check("t4_err", commit_err, 1'b1);
        check("t4_no_w", csr_w_valid, 1'b0);
        check("t4_count", count, 3'd4);
        cyc();
        check("t4_err_pulse", commit_err, 1'b0);

        // Flush with head commit, then commit on empty
        set_cmt(1'b1, 6'd10); cyc();
        check("t5_count3", count, 3'd3);
        set_cmt(1'b1, 6'd11);
        flush_valid = 1'b1;
        set_enq(1'b1, 14'h7, 32'h7, 32'hFFFF_FFFF, 6'd14);
        cyc();
        flush_valid = 1'b0;
        set_enq(1'b0, 14'h0, 32'h0, 32'h0, 6'd0);
        check("t5_flush_w", csr_w_valid, 1'b1);
        check("t5_flush_wdata", csr_w_data, 32'h4);
        check("t5_flush_count", count, 3'd0);
        set_cmt(1'b1, 6'd12); cyc();
        set_cmt(1'b0, 6'd0);
        check("t5_post_err", commit_err, 1'b1);
        check("t5_post_no_w", csr_w_valid, 1'b0);
        cyc();
        set_cmt(1'b1, 6'd0); cyc();
        set_cmt(1'b0, 6'd0);
        check("t5_empty_err", commit_err, 1'b1);
        check("t5_empty_count", count, 3'd0);
        cyc();

        // Wrap-around: overlapped enqueue/commit stream of 10 entries
        rd_addr = 14'h30;
        set_enq(1'b1, 14'h30, 32'hA000_0000, 32'h0000_FFFF, 6'd20);
        cyc();
        for (int k = 1; k < 10; k++) begin
            set_enq(1'b1, 14'h30, 32'hA000_0000 + 32'(k), 32'h0000_FFFF, 6'(20 + k));
            set_cmt(1'b1, 6'(19 + k));
            cyc();
            check("t6_wdata", csr_w_data, 32'hA000_0000 + 32'(k - 1));
            check("t6_count", count, 3'd1);
        end
        set_enq(1'b0, 14'h0, 32'h0, 32'h0, 6'd0);
        set_cmt(1'b1, 6'd29);
        cyc();
        set_cmt(1'b0, 6'd0);
        check("t6_last_wdata", csr_w_data, 32'hA000_0009);
        check("t6_final_count", count, 3'd0);
        repeat (2) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
